tm1638_readbytes: RTL and testbench

- Parametrised multi-byte serial reader for the TM1638 key-scan read phase.
- Clocks NUM_BYTES bytes from the device data pin and drives the device clock at a programmable rate.
- Bit order and inter-byte gap are configurable.
- Streams each byte as it completes, and presents all bytes as one packed word at the end.
- Sits below the TM1638 transaction sequencer: the sequencer issues the read command, pulses start, and waits for done.

---
 rtl/tm1638_pkg.sv | 21 ++
 rtl/tm1638_clkgen.sv | 32 +++
 rtl/tm1638_readbytes.sv | 156 +++++++++++++++
 tb/tb_tm1638_readbytes.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 serial interface blocks.
// Holds the read-phase state encoding, the timing defaults for a 500 kHz
// drvclk (shared with the write path) and the key-scan byte count.
package tm1638_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // At 500 kHz drvclk one cycle is 2 us, which already meets the TM1638
    // minimum clock pulse width and data-ready delay without extra padding.
    localparam int TM1638_CLK_DIV_DEFAULT    = 1;
    localparam int TM1638_GAP_CYCLES_DEFAULT = 0;

    // A key scan returns four bytes.
    localparam int TM1638_KEYSCAN_BYTES = 4;

endpackage

// File: rtl/tm1638_clkgen.sv
// Half-period counter for the TM1638 serial clock.
// Ports:
//   drvclk    - driver clock
//   reset     - synchronous active-high reset
//   run       - count while high; counter is held at 0 while low
//   limit     - terminal count (phase length minus 1)
//   phase_end - one-cycle tick on the last cycle of a phase
module tm1638_clkgen (
    input  logic       drvclk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] limit,
    output logic       phase_end
);

    logic [7:0] cnt;

    assign phase_end = run && (cnt == limit);

    // The counter restarts from 0 on every tick, so a new phase can begin
    // on the same edge the previous one ends, whatever its length.
    always_ff @(posedge drvclk) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (!run || phase_end) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/tm1638_readbytes.sv
// Multi-byte serial reader for the TM1638 key-scan read phase.
// Clocks NUM_BYTES bytes in from dev_din while driving dev_clk, streams each
// byte as it completes and presents the packed result at the end.
// Ports:
//   drvclk     - driver clock (only clock)
//   reset      - synchronous active-high reset
//   start      - transaction request, sampled while idle
//   busy       - high from start accept until the done edge
//   done       - one-cycle pulse when the last byte completes
//   byte_valid - one-cycle pulse per completed byte
//   byte_data  - completed byte, held between pulses
//   byte_idx   - index of the byte on byte_data
//   data       - packed result, byte k at [8k+7:8k], updated at done
//   dev_clk    - device serial clock, idles high
//   dev_din    - device serial data (already synchronised)
module tm1638_readbytes
    import tm1638_pkg::*;
#(
    parameter int NUM_BYTES  = TM1638_KEYSCAN_BYTES,
    parameter int CLK_DIV    = TM1638_CLK_DIV_DEFAULT,
    parameter int GAP_CYCLES = TM1638_GAP_CYCLES_DEFAULT,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                   drvclk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic [3:0]             byte_idx,
    output logic [8*NUM_BYTES-1:0] data,
    output logic                   dev_clk,
    input  logic                   dev_din
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES - 1);

    state_t                   state;
    logic [2:0]               bit_cnt;
    logic [3:0]               byte_cnt;
    logic [7:0]               shreg;
    logic [8*NUM_BYTES-1:0]   staging;
    logic [8*NUM_BYTES-1:0]   staged_full;
    logic [2:0]               bit_pos;
    logic [7:0]               limit;
    logic                     run;
    logic                     phase_end;

    assign run   = (state != ST_IDLE);
    assign limit = (state == ST_GAP) ? GAP_LAST : DIV_LAST;

    tm1638_clkgen u_clkgen (
        .drvclk    (drvclk),
        .reset     (reset),
        .run       (run),
        .limit     (limit),
        .phase_end (phase_end)
    );

    always_comb begin
        bit_pos = LSB_FIRST ? bit_cnt : (3'd7 - bit_cnt);
    end

    // Staging contents with the byte just assembled merged in, so the final
    // byte reaches data on the same edge it is reported.
    always_comb begin
        staged_full = staging;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (byte_cnt == 4'(k)) begin
                staged_full[8*k +: 8] = shreg;
            end
        end
    end

    always_ff @(posedge drvclk) begin
        if (reset) begin
            state      <= ST_IDLE;
            dev_clk    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_idx   <= 4'd0;
            data       <= '0;
            staging    <= '0;
            shreg      <= 8'd0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 4'd0;
        end else begin
            done       <= 1'b0;
            byte_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dev_clk <= 1'b1;
                    busy    <= 1'b0;
                    if (start) begin
                        state    <= ST_LOW;
                        dev_clk  <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= 3'd0;
                        byte_cnt <= 4'd0;
                    end
                end
                ST_LOW: begin
                    // Device data is stable by the end of the low phase.
                    if (phase_end) begin
                        shreg[bit_pos] <= dev_din;
                        dev_clk        <= 1'b1;
                        state          <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            dev_clk <= 1'b0;
                            state   <= ST_LOW;
                        end else begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                            byte_idx   <= byte_cnt;
                            staging    <= staged_full;
                            if (byte_cnt == LAST_BYTE) begin
                                data  <= staged_full;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else if (GAP_CYCLES == 0) begin
                                dev_clk  <= 1'b0;
                                bit_cnt  <= 3'd0;
                                byte_cnt <= byte_cnt + 4'd1;
                                state    <= ST_LOW;
                            end else begin
                                // dev_clk is already high and simply stays there.
                                state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
                        dev_clk  <= 1'b0;
                        bit_cnt  <= 3'd0;
                        byte_cnt <= byte_cnt + 4'd1;
                        state    <= ST_LOW;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_readbytes.sv
module tb_tm1638_readbytes;

    logic clk;
    logic rst;
    logic start_s [4];
    logic dclk    [4];
    logic busy_s  [4];
    logic done_s  [4];
    logic bv_s    [4];
    logic [7:0] bd_s [4];
    logic [3:0] bi_s [4];
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [15:0] data_c;
    logic [7:0]  data_d;
    logic din_a, din_b, din_c, din_d;

    logic [7:0] dev_bytes [4][16];
    int         bit_ptr   [4];
    logic [7:0] tx        [16];

    int checks = 0;
    int errors = 0;

    // Per-instance configuration: A, B, C, D
    int nb_p  [4] = '{4, 4, 2, 1};
    int div_p [4] = '{1, 1, 3, 1};
    int gap_p [4] = '{0, 0, 5, 0};
    bit lsb_p [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tm1638_readbytes #(.NUM_BYTES(4), .CLK_DIV(1), .GAP_CYCLES(0), .LSB_FIRST(1'b1)) u_a (
        .drvclk(clk), .reset(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .byte_valid(bv_s[0]), .byte_data(bd_s[0]), .byte_idx(bi_s[0]), .data(data_a),
        .dev_clk(dclk[0]), .dev_din(din_a));
    tm1638_readbytes #(.NUM_BYTES(4), .CLK_DIV(1), .GAP_CYCLES(0), .LSB_FIRST(1'b0)) u_b (
        .drvclk(clk), .reset(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .byte_valid(bv_s[1]), .byte_data(bd_s[1]), .byte_idx(bi_s[1]), .data(data_b),
        .dev_clk(dclk[1]), .dev_din(din_b));
    tm1638_readbytes #(.NUM_BYTES(2), .CLK_DIV(3), .GAP_CYCLES(5), .LSB_FIRST(1'b1)) u_c (
        .drvclk(clk), .reset(rst), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .byte_valid(bv_s[2]), .byte_data(bd_s[2]), .byte_idx(bi_s[2]), .data(data_c),
        .dev_clk(dclk[2]), .dev_din(din_c));
    tm1638_readbytes #(.NUM_BYTES(1), .CLK_DIV(1), .GAP_CYCLES(0), .LSB_FIRST(1'b1)) u_d (
        .drvclk(clk), .reset(rst), .start(start_s[3]), .busy(busy_s[3]), .done(done_s[3]),
        .byte_valid(bv_s[3]), .byte_data(bd_s[3]), .byte_idx(bi_s[3]), .data(data_d),
        .dev_clk(dclk[3]), .dev_din(din_d));

    function automatic logic [31:0] data_of(input int k);
        case (k)
            0:       return data_a;
            1:       return data_b;
            2:       return {16'd0, data_c};
            default: return {24'd0, data_d};
        endcase
    endfunction

    // Device model: the TM1638 shifts its bytes out LSB first, a new bit
    // after every falling edge of dev_clk.
    task automatic next_bit(input int k, output logic b);
        if (bit_ptr[k] < 128) b = dev_bytes[k][bit_ptr[k] / 8][bit_ptr[k] % 8];
        else                  b = 1'b0;
        bit_ptr[k] = bit_ptr[k] + 1;
    endtask

    initial begin din_a = 1'b0; forever begin @(negedge dclk[0]); next_bit(0, din_a); end end
    initial begin din_b = 1'b0; forever begin @(negedge dclk[1]); next_bit(1, din_b); end end
    initial begin din_c = 1'b0; forever begin @(negedge dclk[2]); next_bit(2, din_c); end end
    initial begin din_d = 1'b0; forever begin @(negedge dclk[3]); next_bit(3, din_d); end end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: plain start pulse; 1: extra start pulses at cycles 10 and 40;
    // 2: start held high, second accept checked after done; 3: reset at cycle 20.
    // pre=1: the accept edge has already happened (continuation of mode 2).
    task automatic run_txn(input int k, input int mode, input bit pre);
        int nb, div, gap, lat, c, nvalid, done_c, len, hi_idx, pos, t;
        bit lsb, done_seen, exp_vld, bad_busy, bad_vld, bad_data, bad_phase;
        logic prevclk;
        logic [7:0] expb [16];
        logic [31:0] expw, prevdata;
        nb = nb_p[k]; div = div_p[k]; gap = gap_p[k]; lsb = lsb_p[k];
        expw = 32'd0;
        for (int i = 0; i < nb; i++) begin
            expb[i] = 8'd0;
            for (int j = 0; j < 8; j++) begin
                pos = lsb ? j : 7 - j;
                expb[i][pos] = tx[i][j];
            end
            expw[8*i +: 8] = expb[i];
        end
        lat = nb * 16 * div + (nb - 1) * gap;
        if (!pre) begin
            for (int i = 0; i < 16; i++) dev_bytes[k][i] = tx[i];
            bit_ptr[k] = 0;
            start_s[k] = 1'b1;
            @(posedge clk); #1;
            if (mode != 2) start_s[k] = 1'b0;
        end
        prevdata = data_of(k);
        c = 0; nvalid = 0; done_c = -1; done_seen = 0;
        bad_busy = 0; bad_vld = 0; bad_data = 0; bad_phase = 0;
        if (dclk[k] !== 1'b0 || busy_s[k] !== 1'b1) bad_busy = 1;
        prevclk = dclk[k]; len = 1; hi_idx = 0;
        while (c < lat + 4 && !done_seen) begin
            @(posedge clk); #1;
            c++;
            if (mode == 1 && (c == 10 || c == 40)) start_s[k] = 1'b1;
            if (mode == 1 && (c == 11 || c == 41)) start_s[k] = 1'b0;
            if (mode == 3 && c == 20) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check("rst_mid_devclk", dclk[k], 1'b1);
                check("rst_mid_busy", busy_s[k], 1'b0);
                check("rst_mid_data", data_of(k), 32'd0);
                check("rst_mid_done", done_s[k], 1'b0);
                check("rst_mid_valid", bv_s[k], 1'b0);
                rst = 1'b0;
                return;
            end
            exp_vld = 0; t = -1;
            for (int i = 0; i < nb; i++)
                if (c == (i + 1) * 16 * div + i * gap) begin exp_vld = 1; t = i; end
            if (bv_s[k] !== exp_vld) bad_vld = 1;
            if (bv_s[k] === 1'b1) nvalid++;
            if (exp_vld) begin
                check("byte_data", bd_s[k], expb[t]);
                check("byte_idx", bi_s[k], t);
            end
            if (busy_s[k] !== (c < lat)) bad_busy = 1;
            if (c < lat && data_of(k) !== prevdata) bad_data = 1;
            if (done_s[k] === 1'b1) begin done_seen = 1; done_c = c; end
            if (dclk[k] === prevclk) len++;
            else begin
                if (prevclk === 1'b0) begin
                    if (len != div) bad_phase = 1;
                end else begin
                    if (len != ((hi_idx % 8 == 7) ? div + gap : div)) bad_phase = 1;
                    hi_idx++;
                end
                len = 1;
                prevclk = dclk[k];
            end
        end
        check("done_cycle", done_c, lat);
        check("data_word", data_of(k), expw);
        check("valid_count", nvalid, nb);
        check("valid_timing", bad_vld, 1'b0);
        check("busy_timing", bad_busy, 1'b0);
        check("data_stable", bad_data, 1'b0);
        check("phase_lengths", bad_phase, 1'b0);
        if (mode == 2) begin
            bit_ptr[k] = 0;
            @(posedge clk); #1;
            check("held_start_reaccept_busy", busy_s[k], 1'b1);
            check("held_start_reaccept_clk", dclk[k], 1'b0);
            start_s[k] = 1'b0;
        end else begin
            @(posedge clk); #1;
            check("idle_after_done", busy_s[k], 1'b0);
            check("idle_devclk", dclk[k], 1'b1);
        end
    endtask

    task automatic rand_tx();
        for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin start_s[k] = 1'b0; bit_ptr[k] = 0; end
        for (int k = 0; k < 4; k++) for (int i = 0; i < 16; i++) dev_bytes[k][i] = 8'd0;
        for (int i = 0; i < 16; i++) tx[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("reset_devclk", dclk[k], 1'b1);
            check("reset_busy", busy_s[k], 1'b0);
            check("reset_done", done_s[k], 1'b0);
            check("reset_valid", bv_s[k], 1'b0);
            check("reset_byte_data", bd_s[k], 8'd0);
            check("reset_byte_idx", bi_s[k], 4'd0);
            check("reset_data", data_of(k), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed key-scan stream, LSB-first and MSB-first receivers
        tx[0] = 8'h01; tx[1] = 8'h80; tx[2] = 8'hA5; tx[3] = 8'h3C;
        run_txn(0, 0, 1'b0);
        check("lsb_first_word", data_a, 32'h3CA58001);
        run_txn(1, 0, 1'b0);
        check("msb_first_word", data_b, 32'h3CA50180);

        // Slow clock with inter-byte gap
        tx[0] = 8'h5A; tx[1] = 8'hC3;
        run_txn(2, 0, 1'b0);

        // start while busy is ignored
        rand_tx();
        run_txn(0, 1, 1'b0);

        // start held high: re-accepted on the edge after done
        rand_tx();
        run_txn(0, 2, 1'b0);
        run_txn(0, 0, 1'b1);

        // Reset in the middle of byte 1, then a clean transaction
        rand_tx();
        run_txn(0, 3, 1'b0);
        rand_tx();
        run_txn(0, 0, 1'b0);

        // Single byte, all ones
        tx[0] = 8'hFF;
        run_txn(3, 0, 1'b0);
        check("single_byte_ff", data_d, 8'hFF);

        // Randomized transactions on every configuration
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                rand_tx();
                run_txn(k, 0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
